// File: rtl/uart_mode2_rx_buf_pkg.sv
// rtl/uart_mode2_rx_buf_pkg.sv - shared UART constants, frame type and mode-2 qualification rule
package uart_mode2_rx_buf_pkg;

  localparam int FRAME_W       = 9;
  localparam int DEFAULT_DEPTH = 4;

  // RB8 value that marks an address frame when SM2 filtering is active
  localparam logic SM2_ADDR_RB8 = 1'b1;

  typedef struct packed {
    logic       rb8;
    logic [7:0] data;
  } frame_t;

  function automatic logic frame_qualified(input logic rx_done, input logic ren,
                                           input logic sm2, input logic rx_rb8);
    return rx_done && ren && (!sm2 || (rx_rb8 == SM2_ADDR_RB8));
  endfunction

endpackage

// File: rtl/uart_mode2_rx_buf_if.sv
// rtl/uart_mode2_rx_buf_if.sv - receiver strobe, CPU read side and status of the mode-2 receive buffer
interface uart_mode2_rx_buf_if
  import uart_mode2_rx_buf_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_rb8;
  logic          rx_done;
  logic          ren;
  logic          sm2;
  logic          rd_en;
  logic          ovr_clr;
  logic [7:0]    sbuf;
  logic          rb8;
  logic          ri;
  logic          overrun;
  logic [CW-1:0] count;

  modport master (
    output rx_data, rx_rb8, rx_done, ren, sm2, rd_en, ovr_clr,
    input  sbuf, rb8, ri, overrun, count
  );

  modport slave (
    input  rx_data, rx_rb8, rx_done, ren, sm2, rd_en, ovr_clr,
    output sbuf, rb8, ri, overrun, count
  );

endinterface

// File: rtl/uart_mode2_rx_buf_sync_fifo.sv
// rtl/uart_mode2_rx_buf_sync_fifo.sv - uart_sync_fifo: power-of-two synchronous FIFO, push/pop/count
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // A pop on a full FIFO frees the slot the same-cycle push lands in
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_mode2_rx_buf.sv
// rtl/uart_mode2_rx_buf.sv - mode-2 receive buffer: SM2/REN filtering, FIFO, sticky overrun
module uart_mode2_rx_buf
  import uart_mode2_rx_buf_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_mode2_rx_buf_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]      count;
  logic [FRAME_W-1:0] head_raw;
  frame_t             head;
  frame_t             wframe;
  logic               qual, full, pop, drop;
  logic               overrun_q, overrun_d;

  // A drop beats a coincident clear so no lost frame goes unreported
  always_comb begin
    qual      = frame_qualified(bus.rx_done, bus.ren, bus.sm2, bus.rx_rb8);
    full      = (count == CW'(DEPTH));
    pop       = bus.rd_en && (count != '0);
    drop      = qual && full && !pop;
    wframe    = '{rb8: bus.rx_rb8, data: bus.rx_data};
    overrun_d = overrun_q;
    if (drop)             overrun_d = 1'b1;
    else if (bus.ovr_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  uart_sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (qual),
    .wdata (wframe),
    .pop   (bus.rd_en),
    .rdata (head_raw),
    .count (count)
  );

  assign head        = frame_t'(head_raw);
  assign bus.ri      = (count != '0);
  assign bus.sbuf    = bus.ri ? head.data : 8'h00;
  assign bus.rb8     = bus.ri ? head.rb8  : 1'b0;
  assign bus.overrun = overrun_q;
  assign bus.count   = count;

endmodule

// File: tb/tb_uart_mode2_rx_buf.sv
// tb/tb_uart_mode2_rx_buf.sv - directed and randomized bench with a queue reference model
module tb_uart_mode2_rx_buf;
  import uart_mode2_rx_buf_pkg::*;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [8:0] q[$];
  logic m_ovr = 1'b0;

  uart_mode2_rx_buf_if #(.DEPTH(DEPTH)) bus ();

  uart_mode2_rx_buf #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [8:0] h;
    h = (q.size() != 0) ? q[0] : 9'h000;
    chk({tag, ".sbuf"},    32'(bus.sbuf),    32'(h[7:0]));
    chk({tag, ".rb8"},     32'(bus.rb8),     32'(h[8]));
    chk({tag, ".ri"},      32'(bus.ri),      32'(q.size() != 0));
    chk({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ovr));
    chk({tag, ".count"},   32'(bus.count),   32'(q.size()));
  endtask

  // Reference: pop first, then push if a slot is free; a qualified frame with no room is dropped
  task automatic cycle(input string tag);
    bit qual, popm, drop;
    qual = bus.rx_done && bus.ren && (!bus.sm2 || bus.rx_rb8);
    popm = bus.rd_en && (q.size() > 0);
    drop = qual && (q.size() == DEPTH) && !popm;
    if (popm) void'(q.pop_front());
    if (qual && !drop) q.push_back({bus.rx_rb8, bus.rx_data});
    if (drop) m_ovr = 1'b1;
    else if (bus.ovr_clr) m_ovr = 1'b0;
    @(posedge clk);
    #1;
    bus.rx_done = 1'b0;
    bus.rd_en   = 1'b0;
    bus.ovr_clr = 1'b0;
    check_all(tag);
  endtask

  task automatic rx(input logic [7:0] d, input logic b);
    bus.rx_data = d;
    bus.rx_rb8  = b;
    bus.rx_done = 1'b1;
  endtask

  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    m_ovr = 1'b0;
    check_all(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_rb8  = 1'b0;
    bus.rx_done = 1'b0;
    bus.ren     = 1'b0;
    bus.sm2     = 1'b0;
    bus.rd_en   = 1'b0;
    bus.ovr_clr = 1'b0;

    #1 rst_n = 1'b0;
    #2 check_all("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    bus.ren = 1'b1;
    rx(8'hA5, 1'b0);     cycle("first_push");
    bus.rd_en = 1'b1;    cycle("first_read");

    bus.sm2 = 1'b1;
    rx(8'h11, 1'b0);     cycle("sm2_data_drop");
    rx(8'h22, 1'b1);     cycle("sm2_addr_keep");
    bus.rd_en = 1'b1;    cycle("sm2_drain");
    bus.sm2 = 1'b0;

    for (int i = 1; i <= 5; i++) begin
      rx(8'(i), 1'b0);   cycle("fill_over");
    end
    for (int i = 0; i < 5; i++) begin
      bus.rd_en = 1'b1;  cycle("drain_order");
    end
    bus.ovr_clr = 1'b1;  cycle("ovr_clear");

    for (int i = 0; i < 4; i++) begin
      rx(8'h31 + 8'(i), i[0]); cycle("fill_full");
    end
    rx(8'h35, 1'b1); bus.rd_en = 1'b1; cycle("full_push_pop");
    for (int i = 0; i < 4; i++) begin
      bus.rd_en = 1'b1;  cycle("full_drain");
    end

    for (int i = 0; i < 3; i++) begin
      rx(8'h40 + 8'(i), 1'b0); cycle("pre_reset_fill");
    end
    async_reset("async_reset");
    rx(8'h5A, 1'b1);     cycle("post_reset_push");

    for (int i = 0; i < 3; i++) begin
      rx(8'h60 + 8'(i), 1'b0); cycle("fill_for_drop");
    end
    rx(8'h99, 1'b0); bus.ovr_clr = 1'b1; cycle("drop_vs_clear");
    bus.ovr_clr = 1'b1;  cycle("clear_alone");
    bus.ren = 1'b0;
    rx(8'h77, 1'b1);     cycle("ren_off_blocks");
    bus.rd_en = 1'b1;    cycle("ren_off_read");
    bus.ren = 1'b1;

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rand_reset");
      end else begin
        bus.ren     = ($urandom_range(0, 99) < 85);
        bus.sm2     = ($urandom_range(0, 99) < 30);
        bus.rx_data = 8'($urandom);
        bus.rx_rb8  = 1'($urandom);
        bus.rx_done = 1'($urandom);
        bus.rd_en   = ($urandom_range(0, 99) < 40);
        bus.ovr_clr = ($urandom_range(0, 99) < 10);
        cycle("random");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_mode2_rx_buf.md
UART_MODE2_RX_BUF -- requirements
Module: uart_mode2_rx_buf

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the number of 9-bit receive FIFO entries; only powers of two from 2 to 16 are legal.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 rx_data  input  8  received data byte from the mode-2 receiver.
REQ-005 rx_rb8  input  1  received 9th bit from the mode-2 receiver.
REQ-006 rx_done  input  1  one-cycle strobe; rx_data/rx_rb8 are valid in this cycle.
REQ-007 ren  input  1  receive enable; SCON.REN equivalent.
REQ-008 sm2  input  1  multiprocessor mode enable; SCON.SM2 equivalent.
REQ-009 rd_en  input  1  CPU read strobe; pops the FIFO head.
REQ-010 ovr_clr  input  1  clears the overrun flag.
REQ-011 sbuf  output  8  data byte of the FIFO head; 0 when empty.
REQ-012 rb8  output  1  9th bit of the FIFO head; 0 when empty.
REQ-013 ri  output  1  receive-interrupt flag; high while the FIFO is non-empty.
REQ-014 overrun  output  1  sticky flag: a qualified frame was dropped.
REQ-015 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 A frame SHALL be qualified when rx_done=1, ren=1 and (sm2=0 or rx_rb8=1); all other rx_done strobes SHALL be discarded with no state change.
REQ-017 A qualified frame SHALL be written as {rx_rb8,rx_data} at the tail in the cycle rx_done is high.
REQ-018 The frame SHALL appear on sbuf/rb8, with ri=1, on the next clock edge when the FIFO was empty (1-cycle latency).
REQ-019 rd_en with count>0 SHALL advance the head on that edge; rd_en with count=0 SHALL be ignored.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and SHALL be accepted even when count=DEPTH.
REQ-021 A qualified frame arriving when count=DEPTH without a same-cycle pop SHALL be dropped, FIFO contents preserved, and overrun set to 1 on the next edge.
REQ-022 overrun SHALL stay 1 until an ovr_clr edge; if a drop and ovr_clr coincide, overrun SHALL be 1 (set wins).
REQ-023 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-024 sbuf/rb8 SHALL be driven combinationally from the head entry, gated to 0 when count=0.
REQ-025 ri SHALL equal (count!=0), registered-consistent with count (no glitching path from rd_en).
REQ-026 Deasserting ren SHALL block new pushes only; stored entries stay readable.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear pointers, count, overrun, and hence sbuf=0, rb8=0, ri=0.
REQ-028 Reset asserted mid-operation SHALL discard all stored frames; FIFO storage contents need not be cleared.
REQ-029 The first rising clk after rst_n deassertion SHALL be able to accept a qualified frame.

Structure
REQ-030 The frame width (9), the default depth and the qualification rule constants SHALL live in the shared UART package used by all mode blocks.
REQ-031 One sub-module SHALL be used: uart_sync_fifo (parameterised width/depth; push/pop/count), instantiated once with width 9.
REQ-032 The SM2/REN qualification and overrun logic SHALL live in uart_mode2_rx_buf itself.

Verification
REQ-033 Reset, then ren=1, sm2=0, rx_done with 0xA5/rb8=0 -> next cycle sbuf=0xA5, rb8=0, ri=1, count=1; rd_en -> ri=0, sbuf=0.
REQ-034 sm2=1, push 0x11/rb8=0 then 0x22/rb8=1 -> only 0x22 stored, count=1, rb8=1.
REQ-035 DEPTH=4: push 0x01..0x05 with no reads -> count=4, overrun=1, reads return 0x01..0x04 in order, then ri=0.
REQ-036 Full FIFO: rx_done and rd_en in the same cycle -> count stays 4, overrun stays 0, new byte is read last.
REQ-037 count=3, rst_n pulsed low between edges -> count=0, ri=0, overrun=0 immediately, without waiting for clk.
REQ-038 Drop and ovr_clr in the same cycle -> overrun=1; a later ovr_clr alone -> overrun=0.
